// File: rtl/mem_read_map_pkg.sv
// Shared definitions for mem_read_map: size encodings, region and state enums,
// default IO timeout and the address-decode / alignment helpers.
package mem_read_map_pkg;

  localparam logic [1:0] MSZ_BYTE = 2'b00;
  localparam logic [1:0] MSZ_HALF = 2'b01;
  localparam logic [1:0] MSZ_WORD = 2'b10;

  localparam int IO_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    REGION_INST,
    REGION_DATA,
    REGION_IO,
    REGION_NONE
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_IO_WAIT
  } state_e;

  // IO outranks everything; data wins over instruction when bits 28 and 29 are both set
  function automatic region_e decode_region(input logic [31:0] addr);
    if (addr[31])      return REGION_IO;
    else if (addr[28]) return REGION_DATA;
    else if (addr[29]) return REGION_INST;
    else               return REGION_NONE;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      MSZ_BYTE: return 1'b0;
      MSZ_HALF: return addr_lo[0];
      default:  return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_read_map_load_extract.sv
// load_extract: selects the byte/half/word lane of a 32-bit word and
// zero- or sign-extends it to 32 bits.
module load_extract
  import mem_read_map_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (mem_size)
      MSZ_BYTE: result = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
      MSZ_HALF: result = {{16{~load_unsigned & half_sel[15]}}, half_sel};
      MSZ_WORD: result = word;
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/mem_read_map.sv
// mem_read_map: stage-3 load path decoding BRAM / IO / unmapped regions, with an
// IO wait state and timeout. Optional misalignment trap: MEM_READ_MAP_MISALIGN_TRAP_EN.
module mem_read_map
  import mem_read_map_pkg::*;
#(
  parameter int IO_TIMEOUT = IO_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic        ReadEnable,
  input  logic [1:0]  MemSize,
  input  logic        LoadUnsigned,
  input  logic [31:0] InstReadData,
  input  logic [31:0] DataReadData,
  output logic        IoReq,
  output logic [31:0] IoAddr,
  input  logic        IoValid,
  input  logic [31:0] IoRdData,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        Stall,
  output logic        IoTimeout,
  output logic        Misaligned
);

  localparam logic [15:0] TMO_LAST = 16'(IO_TIMEOUT - 1);

  state_e      state, state_nxt;
  logic [15:0] cnt;
  logic [31:0] addr_p1;
  logic [1:0]  size_p1;
  logic        uns_p1;
  logic        vld_p1;
  region_e     region_p1;
  logic        mis_p1, mis_in;
  logic        stall_c, zero_res;
  logic [31:0] src_word, ext_word;

`ifdef MEM_READ_MAP_MISALIGN_TRAP_EN
  assign mis_p1 = is_misaligned(addr_p1[1:0], size_p1);
  assign mis_in = is_misaligned(Address[1:0], MemSize);
`else
  assign mis_p1 = 1'b0;
  assign mis_in = 1'b0;
`endif

  assign region_p1 = decode_region(addr_p1);

  // Stage 2 -> stage 3 request registers, frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1 <= '0;
      size_p1 <= '0;
      uns_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (!stall_c) begin
      addr_p1 <= Address;
      size_p1 <= MemSize;
      uns_p1  <= LoadUnsigned;
      vld_p1  <= ReadEnable;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Counts cycles spent stalled in IO_WAIT; zero on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt <= '0;
    else if (state == ST_IO_WAIT && stall_c) cnt <= cnt + 16'd1;
    else                                    cnt <= '0;
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    IoReq     = 1'b0;
    LoadValid = 1'b0;
    IoTimeout = 1'b0;
    zero_res  = 1'b0;
    src_word  = '0;
    case (state)
      ST_IDLE: begin
        LoadValid = vld_p1;
        // an IO region seen here can only be a trapped misaligned access
        zero_res  = mis_p1 || region_p1 == REGION_NONE || region_p1 == REGION_IO;
        src_word  = (region_p1 == REGION_DATA) ? DataReadData : InstReadData;
      end
      ST_IO_WAIT: begin
        IoReq     = 1'b1;
        IoTimeout = !IoValid && cnt == TMO_LAST;
        stall_c   = !IoValid && !IoTimeout;
        LoadValid = !stall_c;
        zero_res  = IoTimeout;
        src_word  = IoRdData;
      end
      default: ;
    endcase
    if (!stall_c)
      state_nxt = (ReadEnable && decode_region(Address) == REGION_IO && !mis_in)
                  ? ST_IO_WAIT : ST_IDLE;
  end

  load_extract u_extract (
    .word          (src_word),
    .addr_lo       (addr_p1[1:0]),
    .mem_size      (size_p1),
    .load_unsigned (uns_p1),
    .result        (ext_word)
  );

  assign LoadData   = (LoadValid && !zero_res) ? ext_word : '0;
  assign Misaligned = LoadValid && mis_p1;
  assign Stall      = stall_c;
  assign IoAddr     = addr_p1;

endmodule

// File: tb/tb_mem_read_map.sv
// Directed bench for mem_read_map: instance a uses the default IO timeout,
// instance b uses IO_TIMEOUT=4; both share the same stimulus.
module tb_mem_read_map;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0, inst_rd = '0, data_rd = '0, io_rd = '0;
  logic        read_en = 1'b0, load_uns = 1'b0, io_valid = 1'b0;
  logic [1:0]  mem_size = '0;

  logic        io_req_a, lv_a, stall_a, tmo_a, mis_a;
  logic [31:0] io_addr_a, ld_a;
  logic        io_req_b, lv_b, stall_b, tmo_b, mis_b;
  logic [31:0] io_addr_b, ld_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_read_map dut_a (
    .clk(clk), .rst_n(rst_n), .Address(address), .ReadEnable(read_en),
    .MemSize(mem_size), .LoadUnsigned(load_uns), .InstReadData(inst_rd),
    .DataReadData(data_rd), .IoReq(io_req_a), .IoAddr(io_addr_a),
    .IoValid(io_valid), .IoRdData(io_rd), .LoadData(ld_a), .LoadValid(lv_a),
    .Stall(stall_a), .IoTimeout(tmo_a), .Misaligned(mis_a)
  );

  mem_read_map #(.IO_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .Address(address), .ReadEnable(read_en),
    .MemSize(mem_size), .LoadUnsigned(load_uns), .InstReadData(inst_rd),
    .DataReadData(data_rd), .IoReq(io_req_b), .IoAddr(io_addr_b),
    .IoValid(io_valid), .IoRdData(io_rd), .LoadData(ld_b), .LoadValid(lv_b),
    .Stall(stall_b), .IoTimeout(tmo_b), .Misaligned(mis_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_lv", lv_a, 0);
    chk("rst_ld", ld_a, 32'h0);
    chk("rst_ioreq", io_req_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_tmo", tmo_a, 0);
    chk("rst_mis", mis_a, 0);
    chk("rst_ioaddr", io_addr_a, 32'h0);
    tick(); rst_n = 1'b1;

    // signed byte from data BRAM, lane 3
    address = 32'h1000_0003; mem_size = 2'b00; load_uns = 1'b0; read_en = 1'b1;
    tick(); data_rd = 32'h8012_3456; read_en = 1'b0; #2;
    chk("byte_s_lv", lv_a, 1);
    chk("byte_s_ld", ld_a, 32'hFFFF_FF80);
    chk("byte_s_mis", mis_a, 0);

    // half from inst BRAM, upper lane, unsigned then signed
    tick(); #2;
    chk("idle_lv", lv_a, 0);
    address = 32'h2000_0002; mem_size = 2'b01; load_uns = 1'b1; read_en = 1'b1;
    tick(); inst_rd = 32'hBEEF_1234; read_en = 1'b0; #2;
    chk("half_u_lv", lv_a, 1);
    chk("half_u_ld", ld_a, 32'h0000_BEEF);
    tick(); load_uns = 1'b0; read_en = 1'b1;
    tick(); read_en = 1'b0; #2;
    chk("half_s_ld", ld_a, 32'hFFFF_BEEF);
    tick(); #2;
    chk("ren0_lv", lv_a, 0);

    // unmapped word returns zero
    address = 32'h0000_0010; mem_size = 2'b10; read_en = 1'b1;
    tick(); read_en = 1'b0; data_rd = 32'hFFFF_FFFF; inst_rd = 32'hFFFF_FFFF; #2;
    chk("unmap_lv", lv_a, 1);
    chk("unmap_ld", ld_a, 32'h0);

    // bits 28 and 29 both set: data wins
    tick(); address = 32'h3000_0000; read_en = 1'b1;
    tick(); read_en = 1'b0; data_rd = 32'h1111_1111; inst_rd = 32'h2222_2222; #2;
    chk("prio_ld", ld_a, 32'h1111_1111);

    // unsigned byte, lane 1
    tick(); address = 32'h1000_0001; mem_size = 2'b00; load_uns = 1'b1; read_en = 1'b1;
    tick(); read_en = 1'b0; data_rd = 32'hA1B2_C3D4; #2;
    chk("byte_u_ld", ld_a, 32'h0000_00C3);

    // IO word, five stall cycles, then data; data load pending behind it
    tick(); address = 32'h8000_0008; mem_size = 2'b10; read_en = 1'b1;
    tick(); address = 32'h1000_0000; #2;
    chk("io_addr", io_addr_a, 32'h8000_0008);
    for (int c = 1; c <= 5; c++) begin
      chk("io_wait_req", io_req_a, 1);
      chk("io_wait_stall", stall_a, 1);
      chk("io_wait_lv", lv_a, 0);
      tick(); #2;
    end
    io_valid = 1'b1; io_rd = 32'hCAFE_F00D; #1;
    chk("io_done_lv", lv_a, 1);
    chk("io_done_ld", ld_a, 32'hCAFE_F00D);
    chk("io_done_stall", stall_a, 0);
    chk("io_done_tmo", tmo_a, 0);
    tick(); io_valid = 1'b0; read_en = 1'b0; data_rd = 32'h5A5A_5A5A; #2;
    chk("b2b_lv", lv_a, 1);
    chk("b2b_ld", ld_a, 32'h5A5A_5A5A);
    chk("b2b_ioreq", io_req_a, 0);

    // timeout on instance b
    tick(); address = 32'h8000_0000; mem_size = 2'b10; read_en = 1'b1;
    tick(); read_en = 1'b0; #2;
    for (int c = 1; c <= 3; c++) begin
      chk("tmo_wait_stall", stall_b, 1);
      chk("tmo_wait_tmo", tmo_b, 0);
      tick(); #2;
    end
    chk("tmo_lv", lv_b, 1);
    chk("tmo_ld", ld_b, 32'h0);
    chk("tmo_pulse", tmo_b, 1);
    chk("tmo_stall", stall_b, 0);
    tick(); #2;
    chk("tmo_after_pulse", tmo_b, 0);
    chk("tmo_after_req", io_req_b, 0);
    chk("tmo_after_lv", lv_b, 0);

    // IoValid in the timeout cycle wins
    address = 32'h8000_0004; read_en = 1'b1;
    tick(); read_en = 1'b0;
    tick(); tick(); tick();
    io_valid = 1'b1; io_rd = 32'h1234_5678; #2;
    chk("coll_lv", lv_b, 1);
    chk("coll_ld", ld_b, 32'h1234_5678);
    chk("coll_tmo", tmo_b, 0);
    chk("coll_a_lv", lv_a, 1);

    // IoValid while idle is ignored
    tick(); #2;
    chk("idle_iov_lv_b", lv_b, 0);
    chk("idle_iov_lv_a", lv_a, 0);
    chk("idle_iov_req", io_req_b, 0);

    // reset while waiting on IO
    tick(); io_valid = 1'b0; address = 32'h8000_000C; read_en = 1'b1;
    tick(); read_en = 1'b0; #2;
    chk("rstw_req_before", io_req_a, 1);
    rst_n = 1'b0; #1;
    chk("rstw_req", io_req_a, 0);
    chk("rstw_stall", stall_a, 0);
    chk("rstw_lv", lv_a, 0);
    tick(); #2;
    chk("rstw_lv_clk", lv_a, 0);
    tick(); rst_n = 1'b1; address = 32'h1000_0004; mem_size = 2'b10; read_en = 1'b1;
    tick(); read_en = 1'b0; data_rd = 32'hDEAD_BEEF; #2;
    chk("post_rst_lv", lv_a, 1);
    chk("post_rst_ld", ld_a, 32'hDEAD_BEEF);

    // misaligned word
    tick(); address = 32'h1000_0002; mem_size = 2'b10; read_en = 1'b1;
    tick(); read_en = 1'b0; data_rd = 32'h0102_0304; #2;
    chk("mis_lv", lv_a, 1);
`ifdef MEM_READ_MAP_MISALIGN_TRAP_EN
    chk("mis_flag", mis_a, 1);
    chk("mis_ld", ld_a, 32'h0);
    tick(); address = 32'h8000_0002; read_en = 1'b1;
    tick(); read_en = 1'b0; #2;
    chk("mis_io_req", io_req_a, 0);
    chk("mis_io_lv", lv_a, 1);
    chk("mis_io_flag", mis_a, 1);
`else
    chk("mis_flag", mis_a, 0);
    chk("mis_ld", ld_a, 32'h0102_0304);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
